// File: rtl/uart_rx_ovs.sv
// UART receiver with 16x oversampling from a free-running tick divider,
// optional parity, error reporting and a show-ahead receive FIFO.
module uart_rx_ovs #(
    parameter int CLK_DIV    = 27,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          rx_status,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    logic                 rx_meta, rx_s;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;

    state_t               state, state_n;
    logic [3:0]           scnt, scnt_n;
    logic [BW-1:0]        bidx, bidx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n;
    logic                 good_c, ferr_c, perr_c;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]        count, count_n;
    logic                 pop, push, full;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (tick_cnt == TW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_cnt <= '0;
        else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            scnt  <= '0;
            bidx  <= '0;
            shreg <= '0;
            perr  <= 1'b0;
        end else begin
            state <= state_n;
            scnt  <= scnt_n;
            bidx  <= bidx_n;
            shreg <= shreg_n;
            perr  <= perr_n;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bidx_n  = bidx;
        shreg_n = shreg;
        perr_n  = perr;
        good_c  = 1'b0;
        ferr_c  = 1'b0;
        perr_c  = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    // scnt counts ticks since the start edge, the detecting tick being 0
                    if (!rx_s) begin
                        state_n = START;
                        scnt_n  = 4'd1;
                        bidx_n  = '0;
                        perr_n  = 1'b0;
                    end
                end
                START: begin
                    if (scnt == 4'd7) begin
                        scnt_n  = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        scnt_n = scnt + 4'd1;
                    end
                end
                DATA: begin
                    if (scnt == 4'd15) begin
                        scnt_n  = '0;
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        if (bidx == BW'(DATA_BITS - 1))
                            state_n = (PARITY != 0) ? PAR : STOP;
                        else
                            bidx_n = bidx + 1'b1;
                    end else begin
                        scnt_n = scnt + 4'd1;
                    end
                end
                PAR: begin
                    if (scnt == 4'd15) begin
                        scnt_n  = '0;
                        perr_n  = ((^shreg) ^ rx_s) != (PARITY == 1);
                        state_n = STOP;
                    end else begin
                        scnt_n = scnt + 4'd1;
                    end
                end
                STOP: begin
                    if (scnt == 4'd15) begin
                        scnt_n = '0;
                        if (!rx_s) begin
                            ferr_c  = 1'b1;
                            state_n = BRK;
                        end else if (perr) begin
                            perr_c  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            good_c  = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        scnt_n = scnt + 4'd1;
                    end
                end
                BRK: begin
                    if (rx_s) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign rx_valid   = (count != '0);
    assign fifo_count = count;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign pop        = rd_en && rx_valid;
    assign push       = good_c && (!full || pop);
    assign rd_ptr_n   = pop ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_n = count;
        if (push && !pop)      count_n = count + 1'b1;
        else if (pop && !push) count_n = count - 1'b1;
    end

    // NOTE: the storage array is deliberately not reset; count and the
    // registered head keep stale entries from ever being observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rx_data    <= '0;
            rx_status  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            // Head follows the new oldest entry, bypassing the array when it is being written now
            if (count_n != '0 && (pop || count == '0))
                rx_data <= (push && wr_ptr == rd_ptr_n) ? shreg : mem[rd_ptr_n];
            rx_status  <= push;
            frame_err  <= ferr_c;
            parity_err <= perr_c;
            if (pop)                  overrun <= 1'b0;
            else if (good_c && !push) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: 8N1 instance and an even-parity instance,
// both at CLK_DIV=4 (64 clk per bit).
module tb_uart_rx_ovs;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       line_a = 1'b1, line_b = 1'b1;
    logic       rd_a = 1'b0, rd_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, st_a, st_b, fe_a, fe_b, pe_a, pe_b, ovr_a, ovr_b;
    logic [2:0] cnt_a, cnt_b;

    int checks = 0;
    int failures = 0;
    int n_st_a = 0, n_fe_a = 0, n_pe_a = 0;
    int n_st_b = 0, n_fe_b = 0, n_pe_b = 0;

    always #5 clk = ~clk;

    uart_rx_ovs #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .uart_rx(line_a), .rd_en(rd_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_status(st_a), .fifo_count(cnt_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a)
    );

    uart_rx_ovs #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) dut_p (
        .clk(clk), .reset(reset), .uart_rx(line_b), .rd_en(rd_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_status(st_b), .fifo_count(cnt_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b)
    );

    always @(negedge clk) begin
        if (st_a) n_st_a++;
        if (fe_a) n_fe_a++;
        if (pe_a) n_pe_a++;
        if (st_b) n_st_b++;
        if (fe_b) n_fe_b++;
        if (pe_b) n_pe_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int ch, input logic v);
        if (ch == 0) line_a = v;
        else         line_b = v;
    endtask

    task automatic bits(input int n);
        repeat (n * BIT) @(negedge clk);
    endtask

    // Leaves the line at the stop-bit level after one stop-bit period
    task automatic send_frame(input int ch, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic stop);
        set_line(ch, 1'b0);
        bits(1);
        for (int i = 0; i < 8; i++) begin
            set_line(ch, d[i]);
            bits(1);
        end
        if (has_par) begin
            set_line(ch, pbit);
            bits(1);
        end
        set_line(ch, stop);
        bits(1);
    endtask

    task automatic pop_a(input string tag, input logic [7:0] exp);
        check(tag, data_a, exp);
        rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
    endtask

    int s0, f0, p0;

    initial begin
        repeat (5) @(negedge clk);
        check("reset_valid", valid_a, 0);
        check("reset_count", cnt_a, 0);
        check("reset_data", data_a, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_flags", {st_a, fe_a, pe_a, ovr_a}, 0);

        // Basic 8N1 frame
        s0 = n_st_a;
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        bits(1);
        check("a5_status", n_st_a - s0, 1);
        check("a5_valid", valid_a, 1);
        check("a5_count", cnt_a, 1);
        pop_a("a5_data", 8'hA5);
        check("a5_pop_valid", valid_a, 0);
        check("a5_pop_count", cnt_a, 0);

        // Even parity: wrong parity bit then correct one
        @(negedge clk);
        s0 = n_st_b; p0 = n_pe_b;
        send_frame(1, 8'h5A, 1, 1'b1, 1'b1);
        bits(1);
        check("par_bad_pe", n_pe_b - p0, 1);
        check("par_bad_nowrite", n_st_b - s0, 0);
        check("par_bad_valid", valid_b, 0);
        send_frame(1, 8'h5A, 1, 1'b0, 1'b1);
        bits(1);
        check("par_good_status", n_st_b - s0, 1);
        check("par_good_pe", n_pe_b - p0, 1);
        check("par_good_data", data_b, 8'h5A);
        check("par_fe", n_fe_b, 0);

        // False start: 3 ticks low
        s0 = n_st_a; f0 = n_fe_a; p0 = n_pe_a;
        set_line(0, 1'b0);
        repeat (12) @(negedge clk);
        set_line(0, 1'b1);
        bits(2);
        check("false_start_pulses", (n_st_a - s0) + (n_fe_a - f0) + (n_pe_a - p0), 0);
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
        bits(1);
        check("after_false_status", n_st_a - s0, 1);
        pop_a("after_false_data", 8'h3C);

        // Overrun: five frames, no reads
        s0 = n_st_a;
        for (int k = 1; k <= 5; k++) begin
            send_frame(0, 8'(k), 0, 1'b0, 1'b1);
            if (k == 4) check("ovr_before_5th", ovr_a, 0);
        end
        bits(1);
        check("ovr_count", cnt_a, 4);
        check("ovr_flag", ovr_a, 1);
        check("ovr_status", n_st_a - s0, 4);
        pop_a("ovr_rd1", 8'h01);
        check("ovr_cleared", ovr_a, 0);
        pop_a("ovr_rd2", 8'h02);
        pop_a("ovr_rd3", 8'h03);
        pop_a("ovr_rd4", 8'h04);
        check("ovr_empty", cnt_a, 0);

        // Bad stop bit followed by a long break
        s0 = n_st_a; f0 = n_fe_a;
        send_frame(0, 8'h00, 0, 1'b0, 1'b0);
        bits(40);
        set_line(0, 1'b1);
        bits(2);
        check("brk_frame_err", n_fe_a - f0, 1);
        check("brk_nowrite", n_st_a - s0, 0);
        send_frame(0, 8'h81, 0, 1'b0, 1'b1);
        bits(1);
        check("brk_after_status", n_st_a - s0, 1);
        check("brk_after_data", data_a, 8'h81);

        // Reset during data bit 4 of 0xFF, with 0x81 still queued
        set_line(0, 1'b0);
        bits(1);
        for (int i = 0; i < 4; i++) begin
            set_line(0, 1'b1);
            bits(1);
        end
        repeat (BIT / 2) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("rst_mid_outputs", {data_a, valid_a, cnt_a, st_a, fe_a, pe_a, ovr_a}, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        bits(1);
        s0 = n_st_a; f0 = n_fe_a; p0 = n_pe_a;
        send_frame(0, 8'h42, 0, 1'b0, 1'b1);
        bits(1);
        check("rst_after_status", n_st_a - s0, 1);
        check("rst_after_errs", (n_fe_a - f0) + (n_pe_a - p0), 0);
        check("rst_after_count", cnt_a, 1);
        pop_a("rst_after_data", 8'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
